// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: ALU operation codes,
// instruction funct encodings, main-decoder classes and FSM states.
package alu_ctrl_pkg;

    localparam logic [3:0] CODE_AND = 4'b0000;
    localparam logic [3:0] CODE_OR  = 4'b0001;
    localparam logic [3:0] CODE_ADD = 4'b0010;
    localparam logic [3:0] CODE_XOR = 4'b0011;
    localparam logic [3:0] CODE_SUB = 4'b0100;
    localparam logic [3:0] CODE_MUL = 4'b0101;
    localparam logic [3:0] CODE_SLT = 4'b0110;
    localparam logic [3:0] CODE_NOR = 4'b0111;
    localparam logic [3:0] CODE_DIV = 4'b1101;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011100;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // IDLE: waiting for a request; BUSY: multi-cycle op counting down;
    // DONE: result held on the output until consumed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_funct_lut.sv
// Combinational decode of main-decoder class and funct field into an ALU
// code, an illegal flag and the multi-cycle class of the operation.
import alu_ctrl_pkg::*;

module alu_funct_lut (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] code,
    output logic       illegal,
    output logic       multi,
    output logic       is_div
);

    // Unmapped funct falls back to ADD with the illegal flag set.
    always_comb begin
        code    = CODE_ADD;
        illegal = 1'b0;
        multi   = 1'b0;
        is_div  = 1'b0;
        case (alu_op)
            ALUOP_SUB: code = CODE_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: code = CODE_ADD;
                    FUNCT_SUB: code = CODE_SUB;
                    FUNCT_AND: code = CODE_AND;
                    FUNCT_OR:  code = CODE_OR;
                    FUNCT_XOR: code = CODE_XOR;
                    FUNCT_NOR: code = CODE_NOR;
                    FUNCT_SLT: code = CODE_SLT;
                    FUNCT_MUL: begin
                        code  = CODE_MUL;
                        multi = 1'b1;
                    end
                    FUNCT_DIV: begin
                        code   = CODE_DIV;
                        multi  = 1'b1;
                        is_div = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            default: code = CODE_ADD;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: accepts decode requests over a valid/ready
// handshake, models MUL/DIV latency with a down-counter and holds the
// resulting ALU control code on a valid/ready output.
//
// state | meaning
// IDLE  | ready for a request, no result pending
// BUSY  | multi-cycle op in flight, counter running down to 0
// DONE  | result valid, held until out_ready
import alu_ctrl_pkg::*;

module alu_ctrl_seq #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              stall
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       lut_code;
    logic             lut_illegal;
    logic             lut_multi;
    logic             lut_div;
    logic             accept;

    alu_funct_lut u_lut (
        .alu_op  (alu_op),
        .funct   (funct),
        .code    (lut_code),
        .illegal (lut_illegal),
        .multi   (lut_multi),
        .is_div  (lut_div)
    );

    // A finishing result and a new request may handshake in the same cycle.
    assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    // Sequencer FSM with latency counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            alu_ctrl  <= '0;
            illegal   <= 1'b0;
            stall     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        alu_ctrl <= CTRL_W'(lut_code);
                        illegal  <= lut_illegal;
                        if (lut_multi) begin
                            state     <= BUSY;
                            cnt       <= lut_div ? DIV_LOAD : MUL_LOAD;
                            stall     <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= DONE;
                            stall     <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        stall     <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                    stall     <= 1'b0;
                end
            endcase
        end
    end

endmodule
